// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the byte-lane mask helper used by the RMW merge path.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        MERGE  = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    // Expands the per-byte enable for an access into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0]  be;
        logic [31:0] m;
        case (f3)
            F3_B, F3_BU: be = LANE_BYTE << off;
            F3_H, F3_HU: be = LANE_HALF << {off[1], 1'b0};
            default:     be = LANE_WORD;
        endcase
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and lane
// replacement for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] wrep;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (funct3)
            F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_val = {24'h0, shifted[7:0]};
            F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_val = {16'h0, shifted[15:0]};
            default: load_val = word;
        endcase
    end

    // Store data is replicated to every lane so the mask alone picks the target.
    always_comb begin
        mask = lane_mask(funct3, offset);
        case (funct3)
            F3_B:    wrep = {4{wdata[7:0]}};
            F3_H:    wrep = {2{wdata[15:0]}};
            default: wrep = wdata;
        endcase
        merged = (word & ~mask) | (wrep & mask);
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only data RAM: sub-word loads with
// extension, SB/SH as read-modify-write, and access checking.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic        accept;
    logic        req_bad;
    logic        f3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        mem_wr;
    logic [31:0] word_addr;
    logic [31:0] align_word;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept    = req_valid && req_ready;
    assign word_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        if (req_we) begin
            f3_ok = req_funct3 inside {F3_B, F3_H, F3_W};
        end else begin
            f3_ok = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
        misaligned = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
                  || (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
        if (req_funct3 == F3_W) begin
            out_of_range = req_addr > LAST_WORD;
        end else begin
            out_of_range = req_addr >= ADDR_LIMIT;
        end
        req_bad = !f3_ok || misaligned || out_of_range;
    end

    // Loads extract from the live RAM word; the merge works on the captured old word.
    assign align_word = (state == MERGE) ? old_q : mem_rdata;

    lsu_align u_align (
        .word     (align_word),
        .offset   (addr_q[1:0]),
        .funct3   (f3_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            old_q      <= 32'h0;
            resp_rdata <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ACCESS && !we_q) begin
                resp_rdata <= load_val;
            end
            if (state == ACCESS && we_q) begin
                old_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        mem_addr   = 32'h0;
        mem_wr     = 1'b0;
        mem_wdata  = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = req_bad ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = word_addr;
                if (we_q && f3_q == F3_W) begin
                    mem_wr    = 1'b1;
                    mem_wdata = wdata_q;
                    state_nx  = RESP;
                end else if (we_q) begin
                    state_nx = MERGE;
                end else begin
                    state_nx = RESP;
                end
            end
            MERGE: begin
                mem_addr  = word_addr;
                mem_wr    = 1'b1;
                mem_wdata = merged;
                state_nx  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A reset arriving mid-store must never commit the write.
    assign mem_we = mem_wr && !rst;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed self-checking bench for lsu_rmw with a behavioural data_ram model.
module tb_lsu_rmw;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic        preload_req;

    int tests;
    int fails;

    logic        obs_valid [1:4];
    logic        obs_err   [1:4];
    logic        obs_we    [1:4];
    logic [31:0] obs_addr  [1:4];
    logic [31:0] obs_wdata [1:4];
    logic [31:0] obs_rdata [1:4];

    lsu_rmw #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[25] <= 32'hDEADBEEF;
            mem[10] <= 32'hCAFEBABE;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic preload();
        @(negedge clk);
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'h5A5A_5A5A;
        for (int k = 1; k <= 4; k++) begin
            obs_valid[k] = resp_valid;
            obs_err[k]   = resp_err;
            obs_we[k]    = mem_we;
            obs_addr[k]  = mem_addr;
            obs_wdata[k] = mem_wdata;
            obs_rdata[k] = resp_rdata;
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b expected 1000", {req_ready, resp_valid, resp_err, mem_we});
        end
        tests++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            fails++;
            $display("[TB] FAIL reset_data: got %h/%h/%h expected zeros", resp_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic check_load(input string name, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] exp);
        run_req(1'b0, f3, a, 32'h0);
        tests++;
        if (obs_valid[1] !== 1'b0 || obs_valid[2] !== 1'b1 || obs_err[2] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_timing: got valid=%b%b err=%b expected 01 0", name, obs_valid[1], obs_valid[2], obs_err[2]);
        end
        tests++;
        if (obs_rdata[2] !== exp) begin
            fails++;
            $display("[TB] FAIL %s_data: got %h expected %h", name, obs_rdata[2], exp);
        end
        tests++;
        if ({obs_we[1], obs_we[2], obs_we[3], obs_we[4]} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL %s_nowrite: got we=%b%b%b%b expected 0000", name, obs_we[1], obs_we[2], obs_we[3], obs_we[4]);
        end
    endtask

    task automatic test_load_byte();
        preload();
        check_load("lb_65", 3'b000, 32'h65, 32'hFFFFFFBE);
        check_load("lbu_65", 3'b100, 32'h65, 32'h000000BE);
    endtask

    task automatic test_load_half_word();
        preload();
        check_load("lhu_66", 3'b101, 32'h66, 32'h0000DEAD);
        check_load("lh_64", 3'b001, 32'h64, 32'hFFFFBEEF);
        check_load("lw_64", 3'b010, 32'h64, 32'hDEADBEEF);
    endtask

    task automatic test_store_byte();
        preload();
        run_req(1'b1, 3'b000, 32'h29, 32'h123456AA);
        tests++;
        if ({obs_we[1], obs_we[2], obs_we[3]} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL sb_we: got %b%b%b expected 010", obs_we[1], obs_we[2], obs_we[3]);
        end
        tests++;
        if (obs_addr[2] !== 32'h28 || obs_wdata[2] !== 32'hCAFEAABE) begin
            fails++;
            $display("[TB] FAIL sb_write: got addr=%h data=%h expected 00000028 cafeaabe", obs_addr[2], obs_wdata[2]);
        end
        tests++;
        if ({obs_valid[2], obs_valid[3], obs_err[3]} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL sb_resp: got %b%b%b expected 010", obs_valid[2], obs_valid[3], obs_err[3]);
        end
        check_load("lw_28_after_sb", 3'b010, 32'h28, 32'hCAFEAABE);
    endtask

    task automatic test_boundary();
        preload();
        run_req(1'b1, 3'b010, 32'h3FC, 32'h12345678);
        tests++;
        if ({obs_we[1], obs_we[2]} !== 2'b10 || obs_addr[1] !== 32'h3FC || obs_wdata[1] !== 32'h12345678) begin
            fails++;
            $display("[TB] FAIL sw_3fc: got we=%b%b addr=%h data=%h expected 10 000003fc 12345678", obs_we[1], obs_we[2], obs_addr[1], obs_wdata[1]);
        end
        tests++;
        if (obs_valid[2] !== 1'b1 || obs_err[2] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sw_resp: got valid=%b err=%b expected 1 0", obs_valid[2], obs_err[2]);
        end
        check_load("lw_3fc", 3'b010, 32'h3FC, 32'h12345678);
        run_req(1'b1, 3'b001, 32'h3FE, 32'h0000ABCD);
        tests++;
        if (obs_we[2] !== 1'b1 || obs_wdata[2] !== 32'hABCD5678) begin
            fails++;
            $display("[TB] FAIL sh_3fe: got we=%b data=%h expected 1 abcd5678", obs_we[2], obs_wdata[2]);
        end
        check_load("lw_3fc_after_sh", 3'b010, 32'h3FC, 32'hABCD5678);
        check_load("lh_3fe", 3'b001, 32'h3FE, 32'hFFFFABCD);
        check_load("lbu_3ff", 3'b100, 32'h3FF, 32'h000000AB);
    endtask

    task automatic test_errors();
        logic        e_we   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  e_f3   [5] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b100};
        logic [31:0] e_addr [5] = '{32'h66, 32'h65, 32'h400, 32'h28, 32'h400};
        for (int i = 0; i < 5; i++) begin
            run_req(e_we[i], e_f3[i], e_addr[i], 32'hFFFFFFFF);
            tests++;
            if (obs_valid[1] !== 1'b1 || obs_err[1] !== 1'b1 || obs_valid[2] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL err%0d_resp: got valid=%b%b err=%b expected 10 1", i, obs_valid[1], obs_valid[2], obs_err[1]);
            end
            tests++;
            if ({obs_we[1], obs_we[2], obs_we[3], obs_we[4]} !== 4'b0000) begin
                fails++;
                $display("[TB] FAIL err%0d_nowrite: got we=%b%b%b%b expected 0000", i, obs_we[1], obs_we[2], obs_we[3], obs_we[4]);
            end
            tests++;
            if (obs_rdata[1] !== 32'h000000AB) begin
                fails++;
                $display("[TB] FAIL err%0d_rdata_hold: got %h expected 000000ab", i, obs_rdata[1]);
            end
        end
    endtask

    task automatic test_reset_mid_merge();
        preload();
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h28;
        req_wdata  = 32'h00001111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (mem_we !== 1'b1) begin
            fails++;
            $display("[TB] FAIL merge_pre_reset_we: got %b expected 1", mem_we);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL merge_reset_gate: got we=%b valid=%b expected 0 0", mem_we, resp_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL after_reset_ready: got ready=%b valid=%b expected 1 0", req_ready, resp_valid);
        end
        @(posedge clk);
        #1;
        tests++;
        if (resp_valid !== 1'b0 || mem[10] !== 32'hCAFEBABE) begin
            fails++;
            $display("[TB] FAIL aborted_store: got valid=%b mem10=%h expected 0 cafebabe", resp_valid, mem[10]);
        end
        check_load("lw_28_after_abort", 3'b010, 32'h28, 32'hCAFEBABE);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        preload_req = 1'b0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        test_reset();
        test_load_byte();
        test_load_half_word();
        test_store_byte();
        test_boundary();
        test_errors();
        test_reset_mid_merge();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
Load/store unit sitting directly upstream of data_ram, between the core's memory stage and the word-only RAM port (clk, we, addr, din, dout).
- Converts RV32 byte, halfword and word loads and stores into word accesses.
- Sign- or zero-extends load data.
- Implements SB/SH as read-modify-write.
- Flags misaligned, out-of-range or illegal accesses without touching memory.

Parameters:
MEM_BYTES, 1024, size of the data_ram byte address space (256 words); byte addresses >= MEM_BYTES are errors.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  core request; accepted when req_valid && req_ready
req_ready  out  1  high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data; low byte/half used for SB/SH
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid; access rejected
resp_rdata  out  32  load result; registered, held until next response
mem_addr  out  32  word-aligned byte address to data_ram; bits [1:0] always 0
mem_we  out  1  data_ram write enable
mem_wdata  out  32  data_ram din
mem_rdata  in  32  data_ram dout; combinational read of mem_addr in the same cycle

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, req_ready=1 afterwards.
- All request fields are latched on acceptance. Inputs are ignored while busy.
- State machine: IDLE, ACCESS, MERGE, RESP, ERR.
- IDLE:
  - mem_* outputs are 0.
  - On accept, go to ERR if any of the following hold; otherwise go to ACCESS:
    - funct3 is illegal: loads accept only 000/001/010/100/101; stores accept only 000/001/010.
    - H/HU with addr[0]=1.
    - W with addr[1:0]!=0.
    - addr > MEM_BYTES-4 (word access) or addr >= MEM_BYTES (other access).
- ACCESS:
  - mem_addr={addr[31:2],2'b00}.
  - Load: extract the byte/half selected by addr[1:0] from mem_rdata (little-endian), extend per funct3, register into resp_rdata, then go to RESP.
  - SW: mem_we=1, mem_wdata=req_wdata, then go to RESP.
  - SB/SH: capture mem_rdata into old_q, then go to MERGE.
- MERGE:
  - mem_addr is unchanged and mem_we=1.
  - mem_wdata is old_q with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH). Other lanes are untouched.
  - Then go to RESP.
- RESP: resp_valid=1, resp_err=0, then go to IDLE.
- ERR: resp_valid=1, resp_err=1, mem_we=0, resp_rdata unchanged, then go to IDLE.
- Latency from acceptance edge T:
  - Loads and SW: resp_valid in cycle T+2.
  - SB/SH: resp_valid in cycle T+3.
  - Errors: resp_valid in cycle T+1.
- Throughput: the next request can be accepted in the cycle after RESP/ERR, because req_ready returns high in IDLE.
- mem_we is high for exactly one cycle per successful store, never for loads or errors.
- Reset mid-operation: rst high during ACCESS or MERGE forces mem_we=0 in that cycle (mem_we is gated by !rst). No write is committed, and no response is issued for the aborted request.
- Boundaries:
  - Byte offset 3 uses lane [31:24].
  - A halfword at offset 2 uses lane [31:16].
  - The last legal word is MEM_BYTES-4. No address wrap-around.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum encoding.
  - Lane-select helper constants.
- One natural combinational sub-module, lsu_align:
  - Inputs: word, offset, funct3, store data.
  - Outputs: extended load value and merged store word.
  - The FSM lives in lsu_rmw.

Test Plan:
Preload data_ram with mem[25]=DEADBEEF and mem[10]=CAFEBABE for every scenario.
1. LB addr 0x65 -> resp_rdata=FFFFFFBE at T+2; LBU 0x65 -> 000000BE; mem_we stays 0 throughout.
2. LHU addr 0x66 -> 0000DEAD; LH 0x64 -> FFFFBEEF; LW 0x64 -> DEADBEEF at T+2.
3. SB addr 0x29, wdata 0x123456AA -> mem_we high only in cycle T+2 with mem_addr=0x28 and mem_wdata=CAFEAABE; resp_valid at T+3; a following LW 0x28 returns CAFEAABE.
4. SW addr 0x3FC, wdata 12345678 -> write at T+1 and LW 0x3FC returns 12345678. SH addr 0x3FE, wdata 0x0000ABCD -> LW 0x3FC returns ABCD5678.
5. Error cases -> each gives resp_valid=1 and resp_err=1 at T+1, no mem_we pulse, and resp_rdata holds its previous value:
   - LW 0x66 (misaligned).
   - LH 0x65 (misaligned).
   - LW 0x400 (out of range).
   - Store with funct3=100 (illegal).
6. SH 0x28 with rst asserted in the MERGE cycle -> mem_we=0 in that cycle, mem[10] unchanged (CAFEBABE), no resp_valid, and req_ready=1 in the cycle after reset.
